// File: rtl/blink_monitor.sv
// Monitors the blink generator's light output: detects edges, measures each half-period,
// and reports lock status, a sticky error flag and a running toggle count.
module blink_monitor #(
    parameter int EXPECTED_HALF = 9,
    parameter int TOL           = 0,
    parameter int LOCK_COUNT    = 4,
    parameter int WIDTH         = 8,
    parameter int TW            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             light,
    input  logic             clear_err,
    output logic             rise,
    output logic             fall,
    output logic             period_valid,
    output logic [WIDTH-1:0] half_period,
    output logic             locked,
    output logic             err,
    output logic [TW-1:0]    toggle_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam int MW     = $clog2(LOCK_COUNT + 1);
    localparam int LO_INT = (EXPECTED_HALF > TOL) ? EXPECTED_HALF - TOL : 0;
    localparam int HI_INT = EXPECTED_HALF + TOL;

    // Window bounds carry one extra bit so EXPECTED_HALF+TOL cannot wrap.
    localparam logic [WIDTH:0]   LO      = LO_INT[WIDTH:0];
    localparam logic [WIDTH:0]   HI      = HI_INT[WIDTH:0];
    localparam logic [WIDTH-1:0] RUN_MAX = '1;
    localparam logic [WIDTH-1:0] RUN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]    LOCK_N  = LOCK_COUNT[MW-1:0];

    logic             light_q;
    logic [WIDTH-1:0] run_cnt;
    logic [MW-1:0]    match_cnt;
    logic [1:0]       state;

    logic             edge_det;
    logic             in_range;
    logic             timeout;
    logic [MW-1:0]    match_inc;
    logic [1:0]       state_nx;
    logic [MW-1:0]    match_nx;
    logic             err_set;

    assign edge_det  = light ^ light_q;
    assign in_range  = ({1'b0, run_cnt} >= LO) && ({1'b0, run_cnt} <= HI);
    assign timeout   = !edge_det && (run_cnt == RUN_MAX) && (state != IDLE);
    assign match_inc = match_cnt + 1'b1;

    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    state_nx = MEASURE;
                    match_nx = '0;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    if (in_range) begin
                        match_nx = match_inc;
                        if (match_inc == LOCK_N) state_nx = LOCKED;
                    end else begin
                        match_nx = '0;
                    end
                end else if (timeout) begin
                    state_nx = IDLE;
                    match_nx = '0;
                end
            end
            LOCKED: begin
                // Losing lock by mismatch or by a stalled light both count as errors.
                if (edge_det) begin
                    if (!in_range) begin
                        err_set  = 1'b1;
                        state_nx = MEASURE;
                        match_nx = '0;
                    end
                end else if (timeout) begin
                    err_set  = 1'b1;
                    state_nx = IDLE;
                    match_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                match_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            light_q      <= 1'b0;
            run_cnt      <= '0;
            match_cnt    <= '0;
            state        <= IDLE;
            rise         <= 1'b0;
            fall         <= 1'b0;
            period_valid <= 1'b0;
            half_period  <= '0;
            locked       <= 1'b0;
            toggle_count <= '0;
        end else begin
            light_q      <= light;
            rise         <= light & ~light_q;
            fall         <= ~light & light_q;
            period_valid <= edge_det && (state != IDLE);
            if (edge_det && (state != IDLE)) half_period <= run_cnt;
            if (edge_det) begin
                run_cnt      <= RUN_ONE;
                toggle_count <= toggle_count + 1'b1;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
            state     <= state_nx;
            match_cnt <= match_nx;
            locked    <= (state_nx == LOCKED);
        end
    end

    // A set in the same cycle as clear_err wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            err <= 1'b0;
        else if (err_set)   err <= 1'b1;
        else if (clear_err) err <= 1'b0;
    end

endmodule

// File: doc/blink_monitor.md
# blink_monitor

Downstream consumer of the blink generator's `light` output. It samples `light` on the shared clock and detects rising and falling edges. It measures the half-period in clock cycles between consecutive edges and checks each measurement against an expected value. It reports lock status, a sticky error and a running toggle count to the status logic further down the design.

## Interface

Parameters:
- `EXPECTED_HALF`, default 9: expected clock cycles between consecutive `light` edges.
- `TOL`, default 0: allowed deviation, inclusive. A measurement matches when it lies in [EXPECTED_HALF-TOL, EXPECTED_HALF+TOL].
- `LOCK_COUNT`, default 4: number of consecutive matching measurements required to lock.
- `WIDTH`, default 8: width of the run counter and of `half_period`.
- `TW`, default 16: width of `toggle_count`.

Ports:
- `clk` input, 1 bit: single clock. All logic is clocked on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `light` input, 1 bit: monitored signal, synchronous to `clk`.
- `clear_err` input, 1 bit: synchronous clear of `err`.
- `rise` output, 1 bit: one-cycle pulse on a detected 0→1 edge.
- `fall` output, 1 bit: one-cycle pulse on a detected 1→0 edge.
- `period_valid` output, 1 bit: one-cycle pulse when `half_period` is updated.
- `half_period` output, WIDTH bits: last measured edge-to-edge distance.
- `locked` output, 1 bit: high while in state LOCKED.
- `err` output, 1 bit: sticky error flag.
- `toggle_count` output, TW bits: total edges seen since reset, wraps.

## Operation

Reset behaviour:
- Asserting `rst` immediately forces every register to 0, including mid-operation. This covers `light_q`, `run_cnt`, `match_cnt`, all outputs and state = IDLE.

Edge detection:
- `light_q <= light` every cycle.
- Edge = `light != light_q`.
- `rise <= light & ~light_q`, `fall <= ~light & light_q`.
- If `light` is 1 at the first post-reset sample, that counts as a rise.

Run counter:
- On an edge cycle, `run_cnt <= 1`.
- Otherwise `run_cnt` increments and saturates at 2^WIDTH-1.

State machine:
- IDLE: on an edge, go to MEASURE, `match_cnt <= 0`. No measurement is taken.
- MEASURE:
  - On an edge: `half_period <= run_cnt`, `period_valid <= 1`.
  - On a match: `match_cnt++`. When the new `match_cnt` equals LOCK_COUNT, go to LOCKED.
  - On a mismatch: `match_cnt <= 0`, stay in MEASURE.
- LOCKED:
  - On an edge: measure as in MEASURE.
  - On a mismatch: set `err`, go to MEASURE, `match_cnt <= 0`.
- Timeout, in MEASURE or LOCKED: a non-edge cycle with `run_cnt == 2^WIDTH-1` goes to IDLE with `match_cnt <= 0`. It also sets `err` if the block was LOCKED. No `period_valid` is produced.
- `locked` is registered: `locked == (state == LOCKED)`.

Error flag:
- `clear_err` clears `err` on the next edge of `clk`.
- A simultaneous set and clear leaves `err = 1` (set wins).

Toggle count:
- `toggle_count` increments on every edge in any state and wraps from 2^TW-1 to 0.

Arithmetic:
- The match compare is unsigned, done at WIDTH+1 bits so that EXPECTED_HALF±TOL cannot wrap.

## Timing

- Latency: `light` sampled changed at edge k gives `rise`/`fall`/`period_valid`/`half_period` valid after edge k+1, i.e. one cycle.
- `toggle_count` updates on that same edge.
- `locked` rises on the same cycle as the `period_valid` of the LOCK_COUNT-th consecutive match.
- `locked` falls on the same cycle as the mismatching `period_valid`, or as the timeout.
- `err` is set on those same cycles.
- Edges spaced N cycles apart measure `half_period = N`. The minimum measurable N is 1, for `light` toggling every cycle.
- There is no backpressure; all pulses last exactly one cycle.

## Test plan

- Reset check: hold `rst` with `light` toggling. All outputs stay 0. Release `rst`; outputs stay 0 until the first `light` edge is sampled.
- Nominal lock: `light` starts at 0 and toggles every 9 clocks (defaults).
  - Edge 1: `rise` pulse only, no `period_valid`.
  - Edges 2–5: `period_valid` with `half_period = 9`.
  - `locked = 1` coincides with the edge-5 `period_valid`.
  - `toggle_count = 5`, `err = 0`.
- Glitch while locked: one half-period of 7 cycles.
  - That edge gives `half_period = 7`, `locked = 0`, `err = 1`.
  - After 4 more 9-cycle halves, `locked = 1` again and `err` stays 1.
- Timeout: `WIDTH = 4`, lock on 9-cycle toggling, then hold `light`.
  - 15 cycles after the last edge, state goes to IDLE, `locked = 0`, `err = 1`.
  - The next edge produces no `period_valid`.
- Clear race:
  - Assert `clear_err` on the same cycle as a mismatch: `err` stays 1.
  - Assert `clear_err` alone next cycle: `err = 0`.
- Async reset mid-run: while locked, pulse `rst` between clock edges. All outputs drop to 0 immediately, without waiting for a clock edge, and the lock sequence restarts from IDLE.
